// File: rtl/counter_mod.sv
`default_nettype none
// ============================================================================
// Module   : counter_mod
// Brief    : Modulo-(MAX+1) up/down counter with parallel load, one-shot mode
//            and terminal-count pulse. Optional prescaler: COUNTER_PRESCALER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module counter_mod #(
    parameter int N   = 26,
    parameter int MAX = 2**N - 1,
    parameter int DIV = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en,
    input  logic         up,
    input  logic         oneshot,
    input  logic         start,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] data,
    output logic         tc,
    output logic         busy
);

    localparam logic [N-1:0] c_max = N'(MAX);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] data_q, data_d;
    logic         tc_q, tc_d;
    logic         tick;
    logic [N-1:0] term;
    logic [N-1:0] restart;
    logic [N-1:0] stepped;

`ifdef COUNTER_PRESCALER_EN
    localparam int              c_pw       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_pw-1:0] c_pre_last = c_pw'(DIV - 1);

    logic [c_pw-1:0] pre_q, pre_d;

    assign tick = en && (pre_q == c_pre_last);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    localparam int unused_div = DIV;

    assign tick = en;
`endif

    // Terminal and restart values track the current direction.
    assign term    = up ? c_max : '0;
    assign restart = up ? '0 : c_max;

    always_comb begin
        stepped = '0;
        if (up) begin
            stepped = (data_q == c_max) ? '0 : data_q + 1'b1;
        end else begin
            stepped = (data_q == '0) ? c_max : data_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        tc_d    = 1'b0;
`ifdef COUNTER_PRESCALER_EN
        pre_d   = pre_q;
        if (en) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
`endif
        if (load) begin
            data_d  = (load_val > c_max) ? c_max : load_val;
            state_d = ST_IDLE;
`ifdef COUNTER_PRESCALER_EN
            pre_d   = '0;
`endif
        end else if (!oneshot) begin
            state_d = ST_IDLE;
            if (tick) begin
                data_d = stepped;
                tc_d   = (data_q == term);
            end
        end else if (state_q == ST_IDLE) begin
            if (start && en) begin
                state_d = ST_RUN;
                if (data_q == term) begin
                    data_d = restart;
                end
`ifdef COUNTER_PRESCALER_EN
                pre_d = '0;
`endif
            end
        end else if (tick) begin
            // One-shot never wraps: a wrap or arrival both end the run at term.
            if ((data_q == term) || (stepped == term)) begin
                data_d  = term;
                tc_d    = 1'b1;
                state_d = ST_IDLE;
            end else begin
                data_d = stepped;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tc_q    <= tc_d;
        end
    end

    assign data = data_q;
    assign tc   = tc_q;
    assign busy = (state_q == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_counter_mod.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_mod
// Brief    : Self-checking bench for counter_mod (N=4, MAX=9): vector table,
//            prescaler sequence and randomized run against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_mod;

    localparam int c_n   = 4;
    localparam int c_max = 9;
    localparam int c_div = 3;

    logic           clk = 1'b0;
    logic           rstn, en, up, oneshot, start, load;
    logic [c_n-1:0] load_val;
    logic [c_n-1:0] data;
    logic           tc, busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_data = 0;
    int m_tc   = 0;
    int m_run  = 0;
    int m_pre  = 0;

    counter_mod #(.N(c_n), .MAX(c_max), .DIV(c_div)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .up       (up),
        .oneshot  (oneshot),
        .start    (start),
        .load     (load),
        .load_val (load_val),
        .data     (data),
        .tc       (tc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r, e, u, o, s, l;
        int lv;
        int d;
        bit t, b;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit r, bit e, bit u, bit o, bit s, bit l, int lv,
                                int d, bit t, bit b);
        vec_t v;
        v.r = r; v.e = e; v.u = u; v.o = o; v.s = s; v.l = l; v.lv = lv;
        v.d = d; v.t = t; v.b = b;
        vecs.push_back(v);
    endfunction

    // Behavioural model: integer arithmetic modulo MAX+1, run flag for one-shot.
    task automatic model_edge(bit r, bit e, bit u, bit o, bit s, bit l, int lv);
        int tick;
        int term;
        int n;
        if (!r) begin
            m_data = 0; m_tc = 0; m_run = 0; m_pre = 0;
            return;
        end
`ifdef COUNTER_PRESCALER_EN
        tick = (e && m_pre == c_div - 1) ? 1 : 0;
`else
        tick = e ? 1 : 0;
`endif
        term = u ? c_max : 0;
        m_tc = 0;
        if (e) m_pre = (m_pre + 1) % c_div;
        if (l) begin
            m_data = (lv > c_max) ? c_max : lv;
            m_run  = 0;
            m_pre  = 0;
        end else if (!o) begin
            m_run = 0;
            if (tick != 0) begin
                n      = u ? m_data + 1 : m_data - 1;
                m_tc   = (n > c_max || n < 0) ? 1 : 0;
                m_data = (n + c_max + 1) % (c_max + 1);
            end
        end else if (m_run == 0) begin
            if (s && e) begin
                m_run = 1;
                m_pre = 0;
                if (m_data == term) m_data = u ? 0 : c_max;
            end
        end else if (tick != 0) begin
            n = u ? m_data + 1 : m_data - 1;
            if (n > c_max || n < 0 || n == term) begin
                m_data = term; m_tc = 1; m_run = 0;
            end else begin
                m_data = n;
            end
        end
    endtask

    task automatic drive(bit r, bit e, bit u, bit o, bit s, bit l, int lv);
        rstn = r; en = e; up = u; oneshot = o; start = s; load = l;
        load_val = c_n'(lv);
        @(posedge clk);
        model_edge(r, e, u, o, s, l, lv);
        #1;
    endtask

    task automatic check(string name, int d, bit t, bit b);
        checks++;
        if (data !== c_n'(d) || tc !== t || busy !== b) begin
            errors++;
            $display("FAIL %s: got data=%0d tc=%b busy=%b, want data=%0d tc=%b busy=%b",
                     name, data, tc, busy, d, t, b);
        end
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; up = 1'b1; oneshot = 1'b0;
        start = 1'b0; load = 1'b0; load_val = '0;

`ifndef COUNTER_PRESCALER_EN
        // Reset, then free-run up for 12 cycles
        add(0,0,1,0,0,0,0, 0,0,0);
        for (int i = 1; i <= 12; i++) add(1,1,1,0,0,0,0, i % 10, (i == 10), 0);
        // Free-run down from 2, then clamped load
        add(1,1,0,0,0,1,2, 2,0,0);
        add(1,1,0,0,0,0,0, 1,0,0);
        add(1,1,0,0,0,0,0, 0,0,0);
        add(1,1,0,0,0,0,0, 9,1,0);
        add(1,1,0,0,0,0,0, 8,0,0);
        add(1,1,0,0,0,1,15, 9,0,0);
        // One-shot up from 0
        add(1,1,1,0,0,1,0, 0,0,0);
        add(1,1,1,1,1,0,0, 0,0,1);
        for (int i = 1; i <= 9; i++) add(1,1,1,1,0,0,0, i, (i == 9), (i != 9));
        add(1,1,1,1,0,0,0, 9,0,0);
        add(1,1,1,1,1,0,0, 0,0,1);
        add(1,1,1,1,0,0,0, 1,0,1);
        // Load wins over a 9->0 wrap
        add(1,1,1,0,0,1,9, 9,0,0);
        add(1,1,1,0,0,1,5, 5,0,0);
        // Reset mid-run
        add(1,1,1,1,1,0,0, 5,0,1);
        add(1,1,1,1,0,0,0, 6,0,1);
        add(0,1,1,1,0,0,0, 0,0,0);
        // en toggled 1,0,1
        add(1,1,1,0,0,0,0, 1,0,0);
        add(1,0,1,0,0,0,0, 1,0,0);
        add(1,1,1,0,0,0,0, 2,0,0);
        // One-shot down from 3
        add(1,1,0,0,0,1,3, 3,0,0);
        add(1,1,0,1,1,0,0, 3,0,1);
        add(1,1,0,1,0,0,0, 2,0,1);
        add(1,1,0,1,0,0,0, 1,0,1);
        add(1,1,0,1,0,0,0, 0,1,0);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].e, vecs[i].u, vecs[i].o, vecs[i].s, vecs[i].l, vecs[i].lv);
            check($sformatf("vec%0d", i), vecs[i].d, vecs[i].t, vecs[i].b);
        end

        // Auto-repeat: start held high through completion re-arms next edge
        drive(1,1,1,0,0,1,7);
        drive(1,1,1,1,1,0,0); check("rep_arm", 7, 0, 1);
        drive(1,1,1,1,1,0,0); check("rep_8", 8, 0, 1);
        drive(1,1,1,1,1,0,0); check("rep_done", 9, 1, 0);
        drive(1,1,1,1,1,0,0); check("rep_rearm", 0, 0, 1);
        // oneshot dropped mid-run continues free-running
        drive(1,1,1,0,0,0,0); check("drop_os", 1, 0, 0);
`else
        // Prescaler DIV=3: advance every third enabled cycle
        drive(0,0,1,0,0,0,0); check("pre_rst", 0, 0, 0);
        drive(1,1,1,0,0,0,0); check("pre_c1", 0, 0, 0);
        drive(1,1,1,0,0,0,0); check("pre_c2", 0, 0, 0);
        drive(1,1,1,0,0,0,0); check("pre_c3", 1, 0, 0);
        drive(1,1,1,0,0,0,0); check("pre_c4", 1, 0, 0);
        drive(1,0,1,0,0,0,0); check("pre_hold1", 1, 0, 0);
        drive(1,0,1,0,0,0,0); check("pre_hold2", 1, 0, 0);
        drive(1,1,1,0,0,0,0); check("pre_c5", 1, 0, 0);
        drive(1,1,1,0,0,0,0); check("pre_c6", 2, 0, 0);
        drive(1,1,1,0,0,0,0); check("pre_c7", 2, 0, 0);
        drive(1,1,1,0,0,1,5); check("pre_load", 5, 0, 0);
        drive(1,1,1,0,0,0,0); check("pre_l1", 5, 0, 0);
        drive(1,1,1,0,0,0,0); check("pre_l2", 5, 0, 0);
        drive(1,1,1,0,0,0,0); check("pre_l3", 6, 0, 0);
`endif

        // Randomized run against the reference model
        drive(0,0,1,0,0,0,0);
        begin
            bit r_os = 1'b0;
            bit r_up = 1'b1;
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 19) == 0) r_os = ~r_os;
                if ($urandom_range(0, 14) == 0) r_up = ~r_up;
                drive(($urandom_range(0, 49) != 0),
                      ($urandom_range(0, 3) != 0),
                      r_up, r_os,
                      ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 11) == 0),
                      int'($urandom_range(0, 15)));
                check($sformatf("rand%0d", i), m_data, m_tc[0], m_run[0]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_mod.md
# counter_mod

Parametrised modulo counter for the tutorial designs: configurable width and terminal value, up/down direction, parallel load, free-running or one-shot mode, and an optional clock prescaler. It sits between the board clock and LED/timing logic wherever a plain free-running counter is too rigid. It also raises a terminal-count pulse for chaining counters or driving timeouts.

## Interface
- N, 26, counter width in bits (N ≥ 2)
- MAX, 2**N-1, terminal value; count range is 0..MAX (MAX ≤ 2**N-1)
- DIV, 1, prescaler ratio; meaningful only with COUNTER_PRESCALER_EN (DIV ≥ 1)
- clk  input  1  clock, all logic on rising edge
- rstn  input  1  synchronous reset, active-low
- en  input  1  count enable
- up  input  1  direction: 1 = up, 0 = down
- oneshot  input  1  mode: 0 = free-run, 1 = one-shot
- start  input  1  one-shot arm request (level, sampled per cycle)
- load  input  1  parallel load strobe
- load_val  input  N  value to load
- data  output  N  current count, registered
- tc  output  1  terminal-count pulse, registered, one cycle wide
- busy  output  1  high while a one-shot run is in progress

## Operation
- Priority per edge: rstn low > load > start > advance.
- tick: internal advance qualifier; equals en when the prescaler is compiled out.
- Advance (tick=1): up: data==MAX → 0, else +1; down: data==0 → MAX, else −1. Arithmetic is modulo MAX+1, never modulo 2**N.
- load: data ← load_val, clamped to MAX if load_val > MAX; applies regardless of en/state; state → IDLE; tc ← 0; prescaler cleared.
- tc: set for one cycle when an advance wraps (free-run) or reaches the terminal value (one-shot); else 0.
- State machine (two states, IDLE/RUN), active only when oneshot=1:
  - IDLE: data holds; busy=0. start=1 → RUN. If data already equals terminal (MAX up, 0 down), data ← start value (0 up, MAX down) on the same edge.
  - RUN: busy=1; advances on tick. An advance that reaches the terminal value → data = terminal, tc=1, state → IDLE (no wrap).
  - start held high in IDLE after completion re-arms on the next edge (auto-repeat).
- oneshot=0: state forced to IDLE, busy=0; advances on every tick with wrap.
- oneshot dropped during RUN: next edge → IDLE, free-run counting continues from current data.
- up changed mid-count: affects the next advance only; terminal value follows the new direction.
- en=0: data, state and prescaler hold; tc=0.

## Timing
- Reset (rstn low at an edge): data=0, tc=0, busy=0, state=IDLE, prescaler=0. Outputs valid from the first edge after.
- Without prescaler: data changes on the edge where en=1 (one-cycle latency from en to new data).
- tc and the wrapped/terminal data value appear in the same cycle.
- load: data=load_val visible the cycle after the load edge.
- start → busy high the cycle after the start edge; first advance no earlier than that edge's next tick.
- Simultaneous load and wrap: load wins, tc=0.
- Reset mid-run: all state cleared at that edge, no tc.

## Configuration
- COUNTER_PRESCALER_EN defined: internal prescaler counts cycles with en=1 from 0 to DIV−1; tick=1 on the cycle it equals DIV−1, then it returns to 0. Cleared by rstn, load, and start-from-IDLE. First advance occurs DIV enabled cycles after clear. DIV=1 is equivalent to no prescaler.
- Not defined: no prescaler logic, DIV ignored, tick=en.

## Test plan
- N=4, MAX=9, free-run up, en=1 for 12 cycles after reset → data 1..9, 0, 1, 2; tc=1 only in the cycle data=0.
- Free-run down from load_val=2 → data 2, 1, 0, 9, 8; tc=1 in the cycle data=9; load_val=15 → data=9 (clamp).
- oneshot=1, up, start pulsed from data=0 → busy=1, data 1..9, tc=1 with data=9, busy=0 next, data holds 9; start again → restarts from 0.
- load asserted on the same edge as a 9→0 wrap → data=load_val, tc=0; rstn low mid-run → data=0, busy=0, tc=0 next cycle.
- COUNTER_PRESCALER_EN, DIV=3, en=1 → data increments every 3rd cycle; en low for 2 cycles holds prescaler phase; load clears phase (next advance 3 cycles later).
- Without macro, en toggled 1,0,1 → data 1,1,2.
